pipeline_ctrl: RTL and testbench



---
 rtl/cpu_pipe_pkg.sv | 20 ++
 rtl/pipeline_ctrl_if.sv | 45 ++++
 rtl/sat_counter.sv | 37 +++
 rtl/pipeline_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/sequencing controller.
//   state_e    : controller FSM states
//   REG_ZERO   : architectural zero register index (never a real hazard source)
//   CNT_W_DEF  : default performance-counter width
//   SEQ_CNT_W  : width of the stall/drain down-counter (covers reload values 0..6)
package cpu_pipe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STALL,
    DRAIN,
    GRANT
  } state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned SEQ_CNT_W = 3;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline controller and the datapath / external-port owner.
//   master : controller side (drives enables, flushes, grant, counters)
//   slave  : datapath/bench side (drives run request, hazard fields, redirect, ext_req)
interface pipeline_ctrl_if
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             enable;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             branch_taken_ex;
  logic             jump_ex;
  logic             ext_req;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             ext_grant;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  enable, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken_ex, jump_ex, ext_req,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, ext_grant, stall_cnt, flush_cnt
  );

  modport slave (
    output enable, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken_ex, jump_ex, ext_req,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, ext_grant, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones, clears on rst.
//   clk, rst : clock, synchronous active-high reset
//   inc_i    : count this cycle
//   count_o  : current count
module sat_counter
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EX/MEM/WB pipeline.
// Enables/flushes are combinational from state and current inputs so they act
// in the same cycle; state, sequencing count and perf counters are registered.
//   clk, rst : clock, synchronous active-high reset (all outputs 0 while high)
//   bus      : pipeline_ctrl_if master (hazard/redirect/ext_req in; enables,
//              flushes, ext_grant, stall_cnt, flush_cnt out)
module pipeline_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES      = 4,
  parameter int unsigned CNT_W             = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_ctrl_if.master        bus
);

  localparam int unsigned SEQ_W = SEQ_CNT_W;
  // Load-use: the RUN cycle is the first bubble, STALL supplies the rest.
  localparam logic [SEQ_W-1:0] STALL_RELOAD =
    SEQ_W'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);
  localparam logic [SEQ_W-1:0] DRAIN_RELOAD = SEQ_W'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] cnt_q, cnt_d;

  logic hazard_c, redirect_c;
  logic stall_inc, flush_inc;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_en, ext_grant;

  // Load-use hazard against the instruction in ID; r0 never creates one.
  assign hazard_c = bus.ex_mem_read && (bus.ex_rt != REG_ZERO) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
  assign redirect_c = bus.branch_taken_ex || bus.jump_ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, sequencing count and same-cycle pipeline controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    ext_grant   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) state_d = RUN;
      end

      RUN: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          if (redirect_c) begin
            // Wrong-path ID instruction is discarded, so its hazard is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (hazard_c) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_d   = STALL_RELOAD;
              state_d = STALL;
            end
          end else if (bus.ext_req) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            cnt_d       = DRAIN_RELOAD;
            state_d     = DRAIN;
          end
        end
      end

      STALL: begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        stall_inc   = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - SEQ_W'(1);
      end

      DRAIN: begin
        // Bubbles enter at IF/ID; a late redirect still captures its target.
        pc_en       = redirect_c;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        id_ex_flush = redirect_c;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        flush_inc   = redirect_c;
        if (!bus.ext_req)     state_d = RUN;
        else if (cnt_q == '0) state_d = GRANT;
        else                  cnt_d   = cnt_q - SEQ_W'(1);
      end

      GRANT: begin
        ext_grant = 1'b1;
        if (!bus.ext_req) state_d = RUN;
      end

      default: state_d = IDLE;
    endcase

    // Everything quiet while reset is held.
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      ext_grant   = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.ext_grant   = ext_grant;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_inc),
    .count_o (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flush_inc),
    .count_o (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand-held saturation
// sequences and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned LSC  = 2;
  localparam int unsigned DRN  = 4;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  // Control vector order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb, grant
  localparam logic [7:0] C_OFF = 8'b0000_0000;
  localparam logic [7:0] C_RUN = 8'b1101_0110;
  localparam logic [7:0] C_HAZ = 8'b0001_1110;
  localparam logic [7:0] C_RED = 8'b1111_1110;
  localparam logic [7:0] C_DRN = 8'b0111_0110;
  localparam logic [7:0] C_GNT = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(
    .LOAD_STALL_CYCLES (LSC),
    .DRAIN_CYCLES      (DRN),
    .CNT_W             (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       jmp;
    logic       req;
  } vin_t;

  typedef struct {
    vin_t       v;
    logic [7:0] ctl;
    int         st;
    int         fl;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  // Model state: remaining bubbles, remaining drain cycles, port granted, running.
  int m_run, m_stall_left, m_drain_left, m_grant, m_st, m_fl;

  function automatic vin_t mk(input logic r, input logic en, input int rs, input int rt,
                              input logic u, input logic mr, input int ert,
                              input logic br, input logic j, input logic req);
    vin_t v;
    v.rst = r; v.en = en; v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = u;
    v.mr = mr; v.ert = 5'(ert); v.br = br; v.jmp = j; v.req = req;
    return v;
  endfunction

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  task automatic add(input vin_t v, input logic [7:0] ctl, input int st, input int fl);
    vec_t e;
    e.v = v; e.ctl = ctl; e.st = st; e.fl = fl;
    vecs.push_back(e);
  endtask

  task automatic drive(input vin_t v);
    rst                 = v.rst;
    bus.enable          = v.en;
    bus.id_rs           = v.rs;
    bus.id_rt           = v.rt;
    bus.id_uses_rt      = v.uses_rt;
    bus.ex_mem_read     = v.mr;
    bus.ex_rt           = v.ert;
    bus.branch_taken_ex = v.br;
    bus.jump_ex         = v.jmp;
    bus.ext_req         = v.req;
  endtask

  task automatic check(input string name, input logic [7:0] ectl, input int est, input int efl);
    logic [7:0] act;
    act = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
           bus.ex_mem_en, bus.mem_wb_en, bus.ext_grant};
    checks++;
    if (act !== ectl || int'(bus.stall_cnt) != est || int'(bus.flush_cnt) != efl) begin
      failures++;
      $display("FAIL %s t=%0t ctl got=%b exp=%b stall got=%0d exp=%0d flush got=%0d exp=%0d",
               name, $time, act, ectl, bus.stall_cnt, est, bus.flush_cnt, efl);
    end
  endtask

  // Expected controls for this cycle from the behavioural rules; advances model past the edge.
  task automatic model_step(input vin_t v, output logic [7:0] ctl);
    logic haz, red;
    haz = v.mr && (v.ert != 5'd0) && (v.ert == v.rs || (v.uses_rt && v.ert == v.rt));
    red = v.br || v.jmp;
    ctl = C_OFF;
    if (v.rst) begin
      m_run = 0; m_stall_left = 0; m_drain_left = 0; m_grant = 0; m_st = 0; m_fl = 0;
    end else if (m_grant != 0) begin
      ctl = C_GNT;
      if (!v.req) m_grant = 0;
    end else if (m_stall_left > 0) begin
      ctl = C_HAZ;
      m_st = sat(m_st + 1);
      m_stall_left--;
    end else if (m_drain_left > 0) begin
      ctl = red ? C_RED : C_DRN;
      if (red) m_fl = sat(m_fl + 1);
      if (!v.req) m_drain_left = 0;
      else begin
        m_drain_left--;
        if (m_drain_left == 0) m_grant = 1;
      end
    end else if (m_run == 0) begin
      if (v.en) m_run = 1;
    end else if (!v.en) begin
      m_run = 0;
    end else if (red) begin
      ctl = C_RED;
      m_fl = sat(m_fl + 1);
    end else if (haz) begin
      ctl = C_HAZ;
      m_st = sat(m_st + 1);
      m_stall_left = LSC - 1;
    end else if (v.req) begin
      ctl = C_DRN;
      m_drain_left = DRN;
    end else begin
      ctl = C_RUN;
    end
  endtask

  task automatic step(input string name, input vin_t v);
    logic [7:0] ectl;
    int est, efl;
    @(negedge clk);
    drive(v);
    #1;
    est = m_st;
    efl = m_fl;
    model_step(v, ectl);
    check(name, ectl, est, efl);
  endtask

  initial begin
    vin_t pl, rq;
    logic req_hold;

    pl = mk(0, 1, 3, 4, 0, 0, 0, 0, 0, 0);
    rq = mk(0, 1, 3, 4, 0, 0, 0, 0, 0, 1);

    add(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), C_OFF, 0, 0);  // reset held
    add(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), C_OFF, 0, 0);  // IDLE, enable seen
    add(pl,                               C_RUN, 0, 0);
    add(mk(0, 1, 5, 4, 0, 1, 5, 0, 0, 0), C_HAZ, 0, 0);  // load-use on rs
    add(pl,                               C_HAZ, 1, 0);  // second bubble
    add(pl,                               C_RUN, 2, 0);
    add(mk(0, 1, 0, 4, 0, 1, 0, 0, 0, 0), C_RUN, 2, 0);  // r0 is never a hazard
    add(mk(0, 1, 3, 7, 0, 1, 7, 0, 0, 0), C_RUN, 2, 0);  // rt match but rt unused
    add(mk(0, 1, 5, 4, 0, 1, 5, 1, 0, 0), C_RED, 2, 0);  // branch beats hazard
    add(mk(0, 1, 3, 4, 0, 0, 0, 0, 1, 0), C_RED, 2, 1);  // jump
    add(rq,                               C_DRN, 2, 2);  // drain starts
    add(rq,                               C_DRN, 2, 2);
    add(mk(0, 0, 3, 4, 0, 0, 0, 0, 0, 1), C_DRN, 2, 2);  // enable=0 ignored in DRAIN
    add(mk(0, 1, 3, 4, 0, 0, 0, 1, 0, 1), C_RED, 2, 2);  // redirect while draining
    add(rq,                               C_DRN, 2, 3);
    add(mk(0, 0, 3, 4, 0, 0, 0, 0, 0, 1), C_GNT, 2, 3);  // granted, enable=0 ignored
    add(rq,                               C_GNT, 2, 3);
    add(pl,                               C_GNT, 2, 3);  // req dropped, grant still up
    add(pl,                               C_RUN, 2, 3);
    add(rq,                               C_DRN, 2, 3);
    add(pl,                               C_DRN, 2, 3);  // req dropped mid-drain
    add(pl,                               C_RUN, 2, 3);
    add(mk(0, 0, 3, 4, 0, 0, 0, 0, 0, 0), C_OFF, 2, 3);  // freeze
    add(mk(0, 0, 5, 4, 0, 1, 5, 0, 0, 0), C_OFF, 2, 3);  // IDLE ignores hazard
    add(pl,                               C_OFF, 2, 3);
    add(rq,                               C_DRN, 2, 3);
    for (int i = 0; i < 4; i++) add(rq,   C_DRN, 2, 3);  // four drain cycles
    add(rq,                               C_GNT, 2, 3);
    add(mk(1, 1, 3, 4, 0, 0, 0, 0, 0, 1), C_OFF, 2, 3);  // reset in GRANT
    add(mk(0, 0, 3, 4, 0, 0, 0, 0, 0, 1), C_OFF, 0, 0);
    add(pl,                               C_OFF, 0, 0);
    add(mk(0, 1, 3, 6, 1, 1, 6, 0, 0, 0), C_HAZ, 0, 0);  // load-use on rt
    add(pl,                               C_HAZ, 1, 0);
    add(pl,                               C_RUN, 2, 0);

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v);
      #1;
      check($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].st, vecs[i].fl);
    end

    // Resynchronise model and DUT with a reset before model-checked traffic.
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    m_run = 0; m_stall_left = 0; m_drain_left = 0; m_grant = 0; m_st = 0; m_fl = 0;

    // Held hazard drives stall_cnt to saturation.
    for (int i = 0; i < 24; i++) step("hold_haz", mk(0, 1, 5, 4, 0, 1, 5, 0, 0, 0));
    @(negedge clk);
    drive(pl);
    #1;
    checks++;
    if (int'(bus.stall_cnt) != MAXC) begin
      failures++;
      $display("FAIL stall_sat got=%0d exp=%0d", bus.stall_cnt, MAXC);
    end
    model_step(pl, req_hold);  // keep model aligned with the cycle just driven

    // Held redirect drives flush_cnt to saturation.
    for (int i = 0; i < 20; i++) step("hold_red", mk(0, 1, 3, 4, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    drive(pl);
    #1;
    checks++;
    if (int'(bus.flush_cnt) != MAXC) begin
      failures++;
      $display("FAIL flush_sat got=%0d exp=%0d", bus.flush_cnt, MAXC);
    end
    model_step(pl, req_hold);

    // Randomized traffic with a sticky ext_req so grants actually happen.
    req_hold = 1'b0;
    for (int i = 0; i < 800; i++) begin
      vin_t v;
      if ($urandom_range(0, 9) == 0) req_hold = ~req_hold;
      v = mk(($urandom_range(0, 79) == 0), ($urandom_range(0, 15) != 0),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), req_hold);
      step("rand", v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
